// File: rtl/mux_recirc_src_ctrl.sv
// Source-side controller for a recirculation-mux CDC transfer: it captures one word,
// holds it stable, and frames it with a fixed-length load-enable pulse for the destination synchronizer.
module mux_recirc_src_ctrl #(
  parameter int WIDTH       = 2,
  parameter int EN_CYCLES   = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             i_c1,
  input  logic             i_rst,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_en_out,
  output logic             o_tx_done,
  output logic [7:0]       o_xfer_cnt
);

  localparam int MAX_CYC = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] EN_LOAD   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  if (WIDTH < 1 || EN_CYCLES < 2 || EN_CYCLES > 15 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
    $error("mux_recirc_src_ctrl: illegal WIDTH/EN_CYCLES/HOLD_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_en_out;
  logic             r_tx_done;
  logic [7:0]       r_xfer_cnt;
  logic             w_in_ready;
  logic             w_accept;

  assign w_in_ready = (r_state == S_IDLE);
  assign w_accept   = i_in_valid & w_in_ready;

  // Transfer sequencer; one down-counter times both the enable window and the hold window.
  always_ff @(posedge i_c1) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_en_out   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_xfer_cnt <= 8'd0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_ASSERT;
            r_cnt      <= EN_LOAD;
            r_data_out <= i_in_data;
            r_en_out   <= 1'b1;
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ASSERT: begin
          if (r_cnt == '0) begin
            r_state  <= S_HOLD;
            r_cnt    <= HOLD_LOAD;
            r_en_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_tx_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          // Unreachable encoding: fall back to a safe quiescent state.
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_en_out <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_data_out = r_data_out;
  assign o_en_out   = r_en_out;
  assign o_tx_done  = r_tx_done;
  assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_mux_recirc_src_ctrl.sv
// Directed bench for mux_recirc_src_ctrl (WIDTH=2, EN_CYCLES=3, HOLD_CYCLES=2); outputs sampled on the falling edge.
module tb_mux_recirc_src_ctrl;

  logic       c1;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic [1:0] data_out;
  logic       en_out;
  logic       tx_done;
  logic [7:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  mux_recirc_src_ctrl #(
    .WIDTH      (2),
    .EN_CYCLES  (3),
    .HOLD_CYCLES(2)
  ) dut (
    .i_c1      (c1),
    .i_rst     (rst),
    .i_in_valid(in_valid),
    .i_in_data (in_data),
    .o_in_ready(in_ready),
    .o_data_out(data_out),
    .o_en_out  (en_out),
    .o_tx_done (tx_done),
    .o_xfer_cnt(xfer_cnt)
  );

  initial c1 = 1'b0;
  always #5 c1 = ~c1;

  task automatic step();
    @(posedge c1);
    @(negedge c1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] en_exp [1:6];
    en_exp[1] = 2'd1; en_exp[2] = 2'd1; en_exp[3] = 2'd1;
    en_exp[4] = 2'd0; en_exp[5] = 2'd0; en_exp[6] = 2'd0;

    // Reset then idle
    rst = 1'b1; in_valid = 1'b0; in_data = 2'b00;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_en_out",   32'(en_out),   32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("rst_tx_done",  32'(tx_done),  32'h0);

    // Single transfer of 10
    in_valid = 1'b1; in_data = 2'b10;
    step();
    in_valid = 1'b0; in_data = 2'b00;
    exp_cnt = 1;
    chk("single_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("single_en_T+%0d", k),       32'(en_out),   32'(en_exp[k]));
      chk($sformatf("single_data_T+%0d", k),     32'(data_out), 32'h2);
      chk($sformatf("single_ready_T+%0d", k),    32'(in_ready), 32'h0);
      chk($sformatf("single_tx_done_T+%0d", k),  32'(tx_done),  32'h0);
      step();
    end
    chk("single_tx_done_T+6", 32'(tx_done),  32'h1);
    chk("single_ready_T+6",   32'(in_ready), 32'h1);
    chk("single_en_T+6",      32'(en_out),   32'h0);
    chk("single_data_T+6",    32'(data_out), 32'h2);
    step();
    chk("single_tx_done_T+7", 32'(tx_done), 32'h0);

    // Back-to-back: 01 then 11 with in_valid held high
    in_valid = 1'b1; in_data = 2'b01;
    step();
    exp_cnt = 2;
    in_data = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("b2b_en_T+%0d", k),   32'(en_out),   32'(en_exp[k]));
      chk($sformatf("b2b_data_T+%0d", k), 32'(data_out), 32'h1);
      if (k < 6) step();
    end
    chk("b2b_ready_T+6",   32'(in_ready), 32'h1);
    chk("b2b_tx_done_T+6", 32'(tx_done),  32'h1);
    step();
    in_valid = 1'b0;
    exp_cnt = 3;
    chk("b2b_data_T+7", 32'(data_out), 32'h3);
    chk("b2b_en_T+7",   32'(en_out),   32'h1);
    chk("b2b_cnt_T+7",  32'(xfer_cnt), 32'(exp_cnt));
    for (int k = 0; k < 5; k++) step();
    chk("b2b_idle_ready", 32'(in_ready), 32'h1);
    step();

    // Busy-ignore: data toggles and in_valid stays high while busy
    in_valid = 1'b1; in_data = 2'b10;
    step();
    exp_cnt = 4;
    for (int k = 1; k <= 5; k++) begin
      in_data = (k % 2 == 1) ? 2'b11 : 2'b00;
      chk($sformatf("busy_data_T+%0d", k),  32'(data_out), 32'h2);
      chk($sformatf("busy_ready_T+%0d", k), 32'(in_ready), 32'h0);
      step();
    end
    in_valid = 1'b0;
    chk("busy_ready_T+6", 32'(in_ready), 32'h1);
    chk("busy_data_T+6",  32'(data_out), 32'h2);
    chk("busy_cnt_T+6",   32'(xfer_cnt), 32'(exp_cnt));
    step();

    // Mid-transfer reset at T+2
    in_valid = 1'b1; in_data = 2'b11;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk("midrst_en",       32'(en_out),   32'h0);
    chk("midrst_data",     32'(data_out), 32'h0);
    chk("midrst_cnt",      32'(xfer_cnt), 32'(exp_cnt));
    chk("midrst_ready",    32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("midrst_no_tx_done_%0d", k), 32'(tx_done), 32'h0);
      chk($sformatf("midrst_no_en_%0d", k),      32'(en_out),  32'h0);
      step();
    end

    // Reset wins over in_valid at the same edge
    rst = 1'b1; in_valid = 1'b1; in_data = 2'b11;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstwin_cnt",  32'(xfer_cnt), 32'h0);
    chk("rstwin_en",   32'(en_out),   32'h0);
    chk("rstwin_data", 32'(data_out), 32'h0);

    // Fresh accept after reset
    in_valid = 1'b1; in_data = 2'b01;
    step();
    in_valid = 1'b0;
    chk("fresh_en",   32'(en_out),   32'h1);
    chk("fresh_data", 32'(data_out), 32'h1);
    chk("fresh_cnt",  32'(xfer_cnt), 32'h1);
    for (int k = 0; k < 5; k++) step();
    chk("fresh_tx_done", 32'(tx_done), 32'h1);

    // Counter wrap: 257 transfers after a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      int guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) begin
        chk("wrap_ready_timeout", 32'(in_ready), 32'h1);
        break;
      end
      in_data = 2'(n);
      step();
      chk($sformatf("wrap_cnt_%0d", n), 32'(xfer_cnt), 32'(n % 256));
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
